board_row_server: RTL and testbench

//  Responder side of the color_mapper row-fetch interface. Holds the 10x20 Tetris board as 16-bit

---
 rtl/tetris_board_pkg.sv | 17 +
 rtl/board_store.sv | 52 +++++
 rtl/board_row_server.sv | 173 +++++++++++++++++
 tb/tb_board_row_server.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_board_pkg.sv
// Shared board geometry, cell/row types and the row-server state encoding.
package tetris_board_pkg;

  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;
  localparam int CELL_W  = 16;

  typedef logic [CELL_W-1:0] cell_t;
  typedef cell_t [BOARD_W-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    CLEAR
  } server_state_t;

endpackage

// File: rtl/board_store.sv
// Tetris board storage: per-row registers with a single-cell write port,
// a combinational cell read and a one-row shift-down used by line clears.
module board_store
  import tetris_board_pkg::*;
(
  input  logic       frame_clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [3:0] wr_x,
  input  logic [4:0] wr_y,
  input  cell_t      wr_data,
  input  logic [7:0] rd_row,
  input  logic [3:0] rd_col,
  output cell_t      rd_data,
  input  logic       shift_en,
  input  logic [4:0] shift_y
);

  row_t rows [BOARD_H];

  for (genvar gi = 0; gi < BOARD_H; gi++) begin : g_row
    row_t row_reg;
    row_t above;

    // Row 0 has nothing above it, so a shift into it clears it.
    if (gi == 0) begin : g_top
      assign above = '0;
    end else begin : g_lower
      assign above = rows[gi-1];
    end

    always_ff @(posedge frame_clk) begin
      if (reset) begin
        row_reg <= '0;
      end else if (shift_en && int'(shift_y) == gi) begin
        row_reg <= above;
      end else if (wr_en && int'(wr_y) == gi && int'(wr_x) < BOARD_W) begin
        row_reg[wr_x] <= wr_data;
      end
    end

    assign rows[gi] = row_reg;
  end

  always_comb begin
    rd_data = '0;
    if (int'(rd_row) < BOARD_H && int'(rd_col) < BOARD_W) begin
      rd_data = rows[rd_row[4:0]][rd_col];
    end
  end

endmodule

// File: rtl/board_row_server.sv
// Row-fetch responder for color_mapper: serves board rows on LD_Row edges,
// accepts cell writes and performs line clears with a deferred-request slot.
module board_row_server
  import tetris_board_pkg::*;
(
  input  logic       frame_clk,
  input  logic       reset,
  input  logic       LD_Row,
  input  logic [7:0] rowNum,
  output row_t       Row,
  output logic       rowReady,
  input  logic       wr_en,
  input  logic [3:0] wr_x,
  input  logic [4:0] wr_y,
  input  cell_t      wr_data,
  input  logic       clr_req,
  input  logic [4:0] clr_row,
  output logic       clr_busy,
  output logic [7:0] lines_cleared
);

  server_state_t state_reg, state_next;
  logic          ld_row_q_reg;
  logic [7:0]    fetch_row_reg, fetch_row_next;
  logic [3:0]    col_reg, col_next;
  logic          pend_reg, pend_next;
  logic [7:0]    pend_row_reg, pend_row_next;
  logic [4:0]    clr_y_reg, clr_y_next;
  row_t          shadow_reg, shadow_next;
  row_t          row_out_reg, row_out_next;
  logic          ready_reg, ready_next;
  logic          busy_reg, busy_next;
  logic [7:0]    lines_reg, lines_next;

  logic  req;
  logic  clr_ok;
  logic  store_wr_en;
  logic  shift_en;
  cell_t rd_data;

  assign req    = LD_Row & ~ld_row_q_reg;
  assign clr_ok = clr_req && int'(clr_row) < BOARD_H;

  board_store u_store (
    .frame_clk (frame_clk),
    .reset     (reset),
    .wr_en     (store_wr_en),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_data   (wr_data),
    .rd_row    (fetch_row_reg),
    .rd_col    (col_reg),
    .rd_data   (rd_data),
    .shift_en  (shift_en),
    .shift_y   (clr_y_reg)
  );

  always_ff @(posedge frame_clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      ld_row_q_reg  <= 1'b0;
      fetch_row_reg <= '0;
      col_reg       <= '0;
      pend_reg      <= 1'b0;
      pend_row_reg  <= '0;
      clr_y_reg     <= '0;
      shadow_reg    <= '0;
      row_out_reg   <= '0;
      ready_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      lines_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      ld_row_q_reg  <= LD_Row;
      fetch_row_reg <= fetch_row_next;
      col_reg       <= col_next;
      pend_reg      <= pend_next;
      pend_row_reg  <= pend_row_next;
      clr_y_reg     <= clr_y_next;
      shadow_reg    <= shadow_next;
      row_out_reg   <= row_out_next;
      ready_reg     <= ready_next;
      busy_reg      <= busy_next;
      lines_reg     <= lines_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    fetch_row_next = fetch_row_reg;
    col_next       = col_reg;
    pend_next      = pend_reg;
    pend_row_next  = pend_row_reg;
    clr_y_next     = clr_y_reg;
    shadow_next    = shadow_reg;
    row_out_next   = row_out_reg;
    ready_next     = ready_reg;
    busy_next      = busy_reg;
    lines_next     = lines_reg;
    store_wr_en    = 1'b0;
    shift_en       = 1'b0;

    case (state_reg)
      IDLE: begin
        store_wr_en = wr_en;
        // A clear wins over a simultaneous request; the request waits in the pending slot.
        if (clr_ok) begin
          state_next = CLEAR;
          clr_y_next = clr_row;
          busy_next  = 1'b1;
          if (req) begin
            pend_next     = 1'b1;
            pend_row_next = rowNum;
          end
        end else if (req) begin
          state_next     = FETCH;
          fetch_row_next = rowNum;
          col_next       = '0;
          ready_next     = 1'b0;
        end
      end

      FETCH: begin
        store_wr_en = wr_en;
        if (req) begin
          fetch_row_next = rowNum;
          col_next       = '0;
        end else if (int'(col_reg) == BOARD_W) begin
          // Whole row published in one edge so the consumer never sees a mix.
          row_out_next = shadow_reg;
          ready_next   = 1'b1;
          state_next   = IDLE;
        end else begin
          shadow_next[col_reg] = rd_data;
          col_next             = col_reg + 4'd1;
        end
      end

      CLEAR: begin
        shift_en = 1'b1;
        if (req) begin
          pend_next     = 1'b1;
          pend_row_next = rowNum;
        end
        if (clr_y_reg == '0) begin
          busy_next = 1'b0;
          if (lines_reg != 8'hFF) begin
            lines_next = lines_reg + 8'd1;
          end
          if (pend_reg || req) begin
            state_next     = FETCH;
            fetch_row_next = req ? rowNum : pend_row_reg;
            col_next       = '0;
            ready_next     = 1'b0;
            pend_next      = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          clr_y_next = clr_y_reg - 5'd1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign Row           = row_out_reg;
  assign rowReady      = ready_reg;
  assign clr_busy      = busy_reg;
  assign lines_cleared = lines_reg;

endmodule

// File: tb/tb_board_row_server.sv
// Directed-plus-random bench for board_row_server with a 2-D array board model.
module tb_board_row_server;
  import tetris_board_pkg::*;

  logic       frame_clk = 1'b0;
  logic       reset     = 1'b1;
  logic       LD_Row    = 1'b0;
  logic [7:0] rowNum    = '0;
  row_t       Row;
  logic       rowReady;
  logic       wr_en     = 1'b0;
  logic [3:0] wr_x      = '0;
  logic [4:0] wr_y      = '0;
  cell_t      wr_data   = '0;
  logic       clr_req   = 1'b0;
  logic [4:0] clr_row   = '0;
  logic       clr_busy;
  logic [7:0] lines_cleared;

  int checks = 0;
  int errors = 0;

  cell_t model [BOARD_H][BOARD_W];
  int    model_lines = 0;

  board_row_server dut (
    .frame_clk     (frame_clk),
    .reset         (reset),
    .LD_Row        (LD_Row),
    .rowNum        (rowNum),
    .Row           (Row),
    .rowReady      (rowReady),
    .wr_en         (wr_en),
    .wr_x          (wr_x),
    .wr_y          (wr_y),
    .wr_data       (wr_data),
    .clr_req       (clr_req),
    .clr_row       (clr_row),
    .clr_busy      (clr_busy),
    .lines_cleared (lines_cleared)
  );

  always #5 frame_clk = ~frame_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic cell_t rand_cell();
    return {4'h0, 12'($urandom)};
  endfunction

  function automatic row_t model_row(input int r);
    row_t e = '0;
    if (r < BOARD_H) begin
      for (int c = 0; c < BOARD_W; c++) e[c] = model[r][c];
    end
    return e;
  endfunction

  // Removing a line: everything above it drops one row, the top row empties.
  task automatic model_clear(input int y);
    for (int r = y; r > 0; r--) model[r] = model[r-1];
    for (int c = 0; c < BOARD_W; c++) model[0][c] = '0;
    model_lines = (model_lines < 255) ? model_lines + 1 : 255;
  endtask

  task automatic write_cell(input int x, input int y, input cell_t d);
    wr_en   = 1'b1;
    wr_x    = 4'(x);
    wr_y    = 5'(y);
    wr_data = d;
    step();
    wr_en = 1'b0;
    if (x < BOARD_W && y < BOARD_H) model[y][x] = d;
  endtask

  task automatic wait_ready(input string tag, input int r, input int hold);
    int n = 0;
    do begin
      if (n >= hold - 1) LD_Row = 1'b0;
      step();
      n++;
    end while (!rowReady && n < 40);
    chk({tag, "/latency"}, 160'(n), 160'(11));
    chk({tag, "/row"}, Row, model_row(r));
  endtask

  task automatic do_request(input string tag, input int r, input int hold);
    rowNum = 8'(r);
    LD_Row = 1'b1;
    step();
    chk({tag, "/ready_low"}, 160'(rowReady), 160'(0));
    wait_ready(tag, r, hold);
  endtask

  task automatic start_clear(input int y);
    clr_req = 1'b1;
    clr_row = 5'(y);
    step();
    clr_req = 1'b0;
  endtask

  task automatic count_busy(input string tag, input int start, input int expected);
    int n = start;
    while (clr_busy && n < 600) begin
      step();
      n++;
    end
    chk({tag, "/busy_cycles"}, 160'(n), 160'(expected));
  endtask

  initial begin
    int   n;
    row_t exp_row;
    cell_t d9;

    for (int r = 0; r < BOARD_H; r++)
      for (int c = 0; c < BOARD_W; c++) model[r][c] = '0;

    // Reset state
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("reset/rowReady", 160'(rowReady), 160'(0));
    chk("reset/Row", Row, '0);
    chk("reset/clr_busy", 160'(clr_busy), 160'(0));
    chk("reset/lines", 160'(lines_cleared), 160'(0));

    // Single write, LD_Row held three cycles gives exactly one fetch
    write_cell(4, 3, 16'h0F00);
    do_request("t1", 3, 3);
    chk("t1/cell4", 160'(Row[4]), 160'(16'h0F00));

    // Out-of-range row numbers read as zeros with normal timing
    for (int c = 0; c < BOARD_W; c++) write_cell(c, 19, rand_cell());
    for (int r = 20; r <= 22; r++) do_request($sformatf("t2_r%0d", r), r, 1);
    do_request("t2_r19", 19, 1);

    // Line clear of row 5 over randomly filled rows 0..6
    for (int r = 0; r <= 6; r++)
      for (int c = 0; c < BOARD_W; c++) write_cell(c, r, rand_cell());
    start_clear(5);
    chk("t3/busy_set", 160'(clr_busy), 160'(1));
    model_clear(5);
    count_busy("t3", 0, 6);
    chk("t3/lines", 160'(lines_cleared), 160'(model_lines));
    for (int r = 0; r <= 6; r++) do_request($sformatf("t3_r%0d", r), r, 1);

    // Request during clear is deferred; a write during clear is dropped
    start_clear(3);
    model_clear(3);
    wr_en   = 1'b1;
    wr_x    = 4'd2;
    wr_y    = 5'd15;
    wr_data = 16'h0ABC;
    step();
    wr_en  = 1'b0;
    rowNum = 8'd3;
    LD_Row = 1'b1;
    step();
    LD_Row = 1'b0;
    chk("t4/ready_held", 160'(rowReady), 160'(1));
    count_busy("t4", 2, 4);
    chk("t4/lines", 160'(lines_cleared), 160'(model_lines));
    wait_ready("t4", 3, 1);
    do_request("t4_dropped_write", 15, 1);

    // Clear and request on the same edge: clear first, then fetch
    clr_req = 1'b1;
    clr_row = 5'd2;
    rowNum  = 8'd1;
    LD_Row  = 1'b1;
    step();
    clr_req = 1'b0;
    LD_Row  = 1'b0;
    model_clear(2);
    chk("t4b/busy_set", 160'(clr_busy), 160'(1));
    count_busy("t4b", 0, 3);
    wait_ready("t4b", 1, 1);

    // Out-of-range clear row is ignored
    start_clear(20);
    chk("t4c/busy_ignored", 160'(clr_busy), 160'(0));
    step();
    chk("t4c/lines", 160'(lines_cleared), 160'(model_lines));

    // Restart: second request four cycles into the fetch
    for (int c = 0; c < BOARD_W; c++) begin
      write_cell(c, 8, rand_cell());
      write_cell(c, 12, rand_cell());
    end
    rowNum = 8'd8;
    LD_Row = 1'b1;
    step();
    LD_Row = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("t5/ready_low", 160'(rowReady), 160'(0));
    rowNum = 8'd12;
    LD_Row = 1'b1;
    step();
    wait_ready("t5", 12, 1);

    // Writes during a fetch: copied column keeps old data, later column shows new
    exp_row = model_row(8);
    d9 = rand_cell() | 16'h0001;
    rowNum = 8'd8;
    LD_Row = 1'b1;
    step();
    LD_Row = 1'b0;
    step();
    write_cell(0, 8, rand_cell() | 16'h0002);
    write_cell(9, 8, d9);
    exp_row[9] = d9;
    n = 3;
    while (!rowReady && n < 40) begin
      step();
      n++;
    end
    chk("t5b/latency", 160'(n), 160'(11));
    chk("t5b/row", Row, exp_row);
    do_request("t5b_after", 8, 1);

    // Line counter saturates at 255
    for (int i = 0; i < 260; i++) begin
      start_clear(0);
      step();
      model_clear(0);
    end
    chk("sat/busy", 160'(clr_busy), 160'(0));
    chk("sat/lines", 160'(lines_cleared), 160'(model_lines));

    // Reset in the middle of a fetch
    for (int c = 0; c < BOARD_W; c++) write_cell(c, 5, rand_cell() | 16'h0100);
    rowNum = 8'd5;
    LD_Row = 1'b1;
    step();
    LD_Row = 1'b0;
    for (int k = 0; k < 5; k++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int r = 0; r < BOARD_H; r++)
      for (int c = 0; c < BOARD_W; c++) model[r][c] = '0;
    model_lines = 0;
    chk("t6/rowReady", 160'(rowReady), 160'(0));
    chk("t6/Row", Row, '0);
    chk("t6/clr_busy", 160'(clr_busy), 160'(0));
    chk("t6/lines", 160'(lines_cleared), 160'(0));
    do_request("t6_board", 5, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
